// File: rtl/irq_priority_ctrl.sv
// rtl/irq_priority_ctrl.sv - Prioritised, nestable interrupt controller with mask and ack handshake.
module irq_priority_ctrl #(
  parameter int          NUM_IRQ    = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0080
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_type,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               irq_ack,
  input  logic               eret,
  output logic               irq_req,
  output logic [1:0]         irq_id,
  output logic [31:0]        irq_vector,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] in_service_q, in_service_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [1:0]         irq_id_q, irq_id_d;
  logic [31:0]        irq_vector_q, irq_vector_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] isr_top;
  logic [NUM_IRQ-1:0] ack_set;
  logic [1:0]         winner;
  logic               ack_fire;

  assign rise     = s2_q & ~s3_q;
  assign ack_fire = (state_q == REQ) && irq_ack;

  // A source is eligible only if no source at or above its own index is in service.
  always_comb begin
    eligible = '0;
    winner   = '0;
    isr_top  = '0;
    ack_set  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      eligible[i] = pending_q[i] & mask_q[i] & ~(|(in_service_q >> i));
      if (eligible[i]) winner = 2'(i);
      if (in_service_q[i]) begin
        isr_top    = '0;
        isr_top[i] = 1'b1;
      end
      if (ack_fire && (irq_id_q == 2'(i))) ack_set[i] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    irq_id_d     = irq_id_q;
    irq_vector_d = irq_vector_q;
    mask_d       = mask_we ? mask_wdata : mask_q;
    // Set wins over the ack clear of the same bit.
    pending_d    = (pending_q & ~ack_set) | rise;
    in_service_d = (in_service_q & ~(eret ? isr_top : '0)) | ack_set;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          irq_id_d     = winner;
          irq_vector_d = VEC_BASE + VEC_STRIDE * {30'd0, winner};
          state_d      = REQ;
        end
      end
      REQ: begin
        if (irq_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '1;
      irq_id_q     <= '0;
      irq_vector_q <= VEC_BASE;
    end else begin
      state_q      <= state_d;
      s1_q         <= irq_type;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      mask_q       <= mask_d;
      irq_id_q     <= irq_id_d;
      irq_vector_q <= irq_vector_d;
    end
  end

  assign irq_req    = (state_q == REQ);
  assign irq_id     = irq_id_q;
  assign irq_vector = irq_vector_q;
  assign mask       = mask_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule
